// File: rtl/rr_burst_arbiter_if.sv
// Handshake bundle between the requesters, the shared burst resource and the arbiter.
// The slave modport is the arbiter's view; master is the requester/resource side.
interface rr_burst_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*LEN_W-1:0] burst_len;
   logic                     res_ready;
   logic [NUM_REQ-1:0]       grant;
   logic [ID_W-1:0]          grant_id;
   logic                     busy;
   logic                     beat_last;
   logic                     done;
   logic                     timeout_err;

   modport master (
      output req, burst_len, res_ready,
      input  grant, grant_id, busy, beat_last, done, timeout_err
   );

   modport slave (
      input  req, burst_len, res_ready,
      output grant, grant_id, busy, beat_last, done, timeout_err
   );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting a shared burst port to one requester at a time,
// holding the grant until len+1 beats are accepted or a stall watchdog aborts.
module rr_burst_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   rr_burst_arbiter_if.slave bus
);
   localparam int ID_W    = $clog2(NUM_REQ);
   localparam int STALL_W = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]      grant_id_q, grant_id_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [LEN_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic                 done_q, done_d;
   logic                 timeout_q, timeout_d;
   logic                 beat_last;

   logic [LEN_W-1:0]     req_len [NUM_REQ];
   logic [ID_W:0]        cand_sum [NUM_REQ];
   logic [ID_W-1:0]      cand_idx [NUM_REQ];
   logic [ID_W-1:0]      win_idx;
   logic                 win_found;
   logic [STALL_W-1:0]   stall_inc;

   // cand_idx[k] is the requester examined k+1 places after the pointer, wrapping.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign req_len[gi]  = bus.burst_len[gi*LEN_W +: LEN_W];
      assign cand_sum[gi] = {1'b0, ptr_q} + (ID_W+1)'(gi + 1);
      assign cand_idx[gi] = (cand_sum[gi] >= (ID_W+1)'(NUM_REQ))
                          ? ID_W'(cand_sum[gi] - (ID_W+1)'(NUM_REQ))
                          : ID_W'(cand_sum[gi]);
   end

   always_comb begin
      win_idx   = '0;
      win_found = |bus.req;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req[cand_idx[k]]) begin
            win_idx = cand_idx[k];
         end
      end
   end

   assign stall_inc = stall_cnt_q + STALL_W'(1);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_id_d  = grant_id_q;
      ptr_d       = ptr_q;
      len_d       = len_q;
      beat_cnt_d  = beat_cnt_q;
      stall_cnt_d = stall_cnt_q;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      beat_last   = 1'b0;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (win_found) begin
               grant_d     = NUM_REQ'(1) << win_idx;
               grant_id_d  = win_idx;
               len_d       = req_len[win_idx];
               beat_cnt_d  = '0;
               stall_cnt_d = '0;
               state_d     = BURST;
            end
         end
         BURST: begin
            if (bus.res_ready) begin
               stall_cnt_d = '0;
               if (beat_cnt_q == len_q) begin
                  beat_last = 1'b1;
                  grant_d   = '0;
                  done_d    = 1'b1;
                  ptr_d     = grant_id_q;
                  state_d   = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + LEN_W'(1);
               end
            end else if (stall_inc == STALL_W'(TIMEOUT)) begin
               // Parking the pointer on the stalled requester demotes it next round.
               grant_d     = '0;
               timeout_d   = 1'b1;
               ptr_d       = grant_id_q;
               stall_cnt_d = '0;
               state_d     = IDLE;
            end else begin
               stall_cnt_d = stall_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         grant_id_q  <= '0;
         ptr_q       <= ID_W'(NUM_REQ - 1);
         len_q       <= '0;
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_id_q  <= grant_id_d;
         ptr_q       <= ptr_d;
         len_q       <= len_d;
         beat_cnt_q  <= beat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.busy        = (state_q == BURST);
   assign bus.beat_last   = beat_last;
   assign bus.done        = done_q;
   assign bus.timeout_err = timeout_q;
endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that shares one burst-oriented resource port inside top_level among NUM_REQ requesters.
- Samples request lines and selects one requester fairly. It latches that requester's burst length and holds a one-hot grant until the resource has accepted every beat.
- A stall watchdog aborts bursts that stop making progress.
- Sits between the requester blocks and the shared resource; purely a controller, no data path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- LEN_W, 4, width of each burst-length field; a burst is len+1 beats (1..2^LEN_W)
- TIMEOUT, 16, consecutive stalled cycles (res_ready low during a burst) before abort; must be >= 1

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- req  input  NUM_REQ  per-requester request level
- burst_len  input  NUM_REQ*LEN_W  packed lengths; requester i uses bits [i*LEN_W +: LEN_W]
- res_ready  input  1  resource accepts a beat this cycle (beat = grant active && res_ready)
- grant  output  NUM_REQ  registered one-hot grant; all-zero when idle
- grant_id  output  clog2(NUM_REQ)  index of current/last granted requester
- busy  output  1  high while in BURST
- beat_last  output  1  combinational: high on the accepted final beat of a burst
- done  output  1  one-cycle pulse the cycle after a burst completes normally
- timeout_err  output  1  one-cycle pulse the cycle after a watchdog abort

Behaviour:
- Reset (reset==0, async): state=IDLE; grant=0, grant_id=0, busy=0, done=0, timeout_err=0; beat counter=0, stall counter=0; rr pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, BURST.
- IDLE, with any req bit high at a rising edge:
  - Winner = first set bit searching upward from pointer+1, modulo NUM_REQ.
  - Register grant[winner]=1, grant_id=winner, latch len=burst_len[winner], beat counter=0, state=BURST.
  - Grant is visible one cycle after req is sampled.
- IDLE, with req all zero: stay in IDLE; grant=0.
- BURST, each cycle:
  - res_ready=1: counts a beat and increments the beat counter; stall counter clears.
  - res_ready=0: stall counter increments.
- Normal completion: when the beat counter equals the latched len and res_ready=1, beat_last=1 that cycle. On the next edge:
  - grant=0, busy=0, done=1 for one cycle;
  - pointer=grant_id; state=IDLE.
- Watchdog abort: when the stall counter reaches TIMEOUT, on that edge:
  - grant=0, busy=0, timeout_err=1 for one cycle;
  - pointer=grant_id, so the stalled requester loses priority; state=IDLE.
- Turnaround: at least one idle cycle (grant all-zero) always separates consecutive grants.
- req and burst_len are sampled only at arbitration. Dropping req mid-burst does not end the burst; changing burst_len mid-burst has no effect.
- len=0: single-beat burst; beat_last is high on the first accepted beat.
- Wrap-around: the pointer search wraps from NUM_REQ-1 to 0. If the only requester is the previous winner, it wins again.
- done and timeout_err are never high in the same cycle.
- Asserting reset mid-burst drops grant immediately (asynchronously) and discards the burst; no done or timeout_err pulse.
- The beat counter is LEN_W bits wide; the stall counter is clog2(TIMEOUT+1) bits wide.

Test Plan:
1. Reset then req=4'b0001, len0=3, res_ready=1 -> grant=0001 one cycle after req; beat_last on the 4th beat; done pulses the next cycle; grant=0 the same cycle.
2. req=4'b1111 held, all len=0, res_ready=1 -> grants in order 0001,0010,0100,1000,0001, each for 1 cycle, separated by 1 idle cycle.
3. After requester 2 wins, req=4'b0101 -> requester 0 wins next, then 2 (wrap-around fairness).
4. Grant to requester 1, len=2; res_ready pattern 1,0,0,1,1 -> beat_last on the 5th cycle; no timeout_err; done=1 once.
5. TIMEOUT=16, grant active, res_ready held 0 -> timeout_err pulses after 16 stalled cycles; grant=0; the next arbitration skips the aborted requester if others request.
6. Reset driven low mid-burst (beat 2 of 4) -> grant=0, busy=0 asynchronously. After release with req=4'b0001, requester 0 wins and the burst restarts at beat 0.
